hazard_forward_unit_p: RTL
==========================

Name: hazard_forward_unit_p

Overview:
- Parametrised next-generation hazard and forwarding unit for the Andes-style 5-stage pipeline, sitting beside the ID stage.
- Forwards EXE and MEM results to NUM_RD ID source ports, with EXE taking priority over MEM and MEM over the register file.
- A small FSM replaces the decode-only stall: it holds a real load-use stall across a variable-latency data memory and inserts configurable branch/jump bubbles.
- A saturating counter records stall cycles for performance analysis.

Parameters:
DATA_W, 32, datapath width
ADDR_W, 5, register address width
NUM_RD, 3, number of ID source ports (reg1, reg2, sw)
BR_BUBBLES, 1, stall cycles per taken branch/jump, legal range 1..15
CNT_W, 16, stall statistics counter width

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset (0 = reset)
id_valid  in  1  ID holds a valid instruction
id_rd_en  in  NUM_RD  per-port read enable
id_rd_addr  in  NUM_RD*ADDR_W  per-port source address; port i at [i*ADDR_W +: ADDR_W]
id_rd_data  in  NUM_RD*DATA_W  register file read data per port
id_is_branch  in  1  ID instruction is a branch/jump
exe_wr_en  in  1  EXE instruction writes a register
exe_wr_addr  in  ADDR_W  EXE destination
exe_is_load  in  1  EXE instruction is a load
exe_data  in  DATA_W  EXE result (ALU or mov, already selected)
mem_wr_en  in  1  MEM instruction writes a register
mem_wr_addr  in  ADDR_W  MEM destination
mem_is_load  in  1  MEM instruction is a load
mem_load_done  in  1  load data valid this cycle
mem_alu_data  in  DATA_W  MEM non-load result
mem_load_data  in  DATA_W  data memory read data
stat_clr  in  1  synchronous clear of stall_cnt
fwd_data  out  NUM_RD*DATA_W  forwarded operand per port
stall_pc  out  1  hold PC
stall_if_id  out  1  hold IF/ID register
flush_id_exe  out  1  insert bubble into ID/EXE
stall_cnt  out  CNT_W  saturating stall-cycle count

Behaviour:
- Forwarding is combinational and evaluated independently per port i:
  - If id_rd_en[i]=0, the port outputs id_rd_data.
  - EXE match (addr equal, exe_wr_en=1, exe_is_load=0): output exe_data.
  - Otherwise, MEM match (addr equal, mem_wr_en=1): output mem_load_data if mem_is_load, else mem_alu_data.
  - Otherwise: output id_rd_data.
  - No register is hardwired to zero; R0 is forwarded like any other register.
- load_use (combinational) = id_valid & exe_is_load & exe_wr_en & (any port i with id_rd_en[i] and id_rd_addr[i]==exe_wr_addr).
- FSM states: RUN, LD_WAIT, BR_HOLD. A 4-bit bubble counter br_cnt is used in BR_HOLD.
- RUN:
  - load_use: assert stall_pc, stall_if_id and flush_id_exe; go to LD_WAIT.
  - else if id_valid & id_is_branch: assert stall_pc and stall_if_id (no flush). Go to BR_HOLD with br_cnt=BR_BUBBLES-1 if BR_BUBBLES>1; otherwise stay in RUN.
  - else: all stall outputs 0.
  - load_use has priority over branch.
- LD_WAIT (the load is now in MEM):
  - mem_load_done=0: stall_pc, stall_if_id and flush_id_exe asserted; stay.
  - mem_load_done=1: all stall outputs 0, MEM forwarding supplies mem_load_data this cycle; go to RUN.
- BR_HOLD: stall_pc and stall_if_id asserted, flush_id_exe=0, br_cnt decrements. Go to RUN after the cycle in which br_cnt==1.
- Each branch therefore produces exactly BR_BUBBLES stall cycles, including the detection cycle.
- stall_cnt:
  - Increments on every clock edge where stall_pc=1 and saturates at all-ones.
  - stat_clr=1 forces 0 on the next edge and wins over increment.
- Reset (rst=0), taking effect immediately including mid-stall: state=RUN, br_cnt=0, stall_cnt=0. stall_pc, stall_if_id and flush_id_exe are forced to 0 while rst=0. fwd_data remains combinational.
- Latency: forwarding 0 cycles; stall outputs respond in the same cycle as detection.

Test Plan:
- Forward priority: port0 addr 3; exe_wr_en=1, exe_wr_addr=3, exe_data=0xAAAA; mem_wr_en=1, mem_wr_addr=3, mem_alu_data=0xBBBB -> fwd port0=0xAAAA. Drop exe_wr_en -> 0xBBBB. Drop mem_wr_en -> id_rd_data.
- Load-use, 3-cycle memory: exe_is_load with exe_wr_addr=5, ID port1 reads 5 -> stall_pc, stall_if_id and flush_id_exe high for 3 cycles (detect plus 2 in LD_WAIT). mem_load_done=1 with mem_load_data=0x1234 -> stalls drop, fwd port1=0x1234; stall_cnt=3.
- Branch with BR_BUBBLES=3: id_is_branch pulse -> stall_pc high for exactly 3 cycles, flush_id_exe never high, FSM back in RUN.
- Simultaneous load_use and id_is_branch -> LD_WAIT path taken, no BR_HOLD entry.
- Saturation and clear with CNT_W=4: hold a load stall for 20 cycles -> stall_cnt stays at 15. Assert stat_clr while stalled -> stall_cnt=0 on the next edge.
- Reset mid-LD_WAIT: assert rst=0 -> stall outputs go 0 immediately. Release -> FSM in RUN, stall_cnt=0.

Source files
------------

// File: rtl/hazard_forward_unit_p.sv
// ID-side hazard unit: per-port EXE/MEM operand forwarding, load-use stall held
// across a variable-latency data memory, branch bubble insertion, stall statistics.
module hazard_forward_unit_p #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned NUM_RD     = 3,
  parameter int unsigned BR_BUBBLES = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [NUM_RD-1:0]        id_rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] id_rd_addr,
  input  logic [NUM_RD*DATA_W-1:0] id_rd_data,
  input  logic                     id_is_branch,
  input  logic                     exe_wr_en,
  input  logic [ADDR_W-1:0]        exe_wr_addr,
  input  logic                     exe_is_load,
  input  logic [DATA_W-1:0]        exe_data,
  input  logic                     mem_wr_en,
  input  logic [ADDR_W-1:0]        mem_wr_addr,
  input  logic                     mem_is_load,
  input  logic                     mem_load_done,
  input  logic [DATA_W-1:0]        mem_alu_data,
  input  logic [DATA_W-1:0]        mem_load_data,
  input  logic                     stat_clr,
  output logic [NUM_RD*DATA_W-1:0] fwd_data,
  output logic                     stall_pc,
  output logic                     stall_if_id,
  output logic                     flush_id_exe,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int unsigned BR_W = 4;

  typedef enum logic [1:0] {RUN, LD_WAIT, BR_HOLD} state_t;

  state_t            state;
  logic [BR_W-1:0]   br_cnt;
  logic [NUM_RD-1:0] exe_dep;
  logic              load_use;
  logic              stall;
  logic              flush;

  // Per-port forwarding mux: EXE (non-load) beats MEM beats register file.
  for (genvar g = 0; g < NUM_RD; g++) begin : g_fwd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rf_data;
    logic [DATA_W-1:0] sel;

    assign addr       = id_rd_addr[g*ADDR_W +: ADDR_W];
    assign rf_data    = id_rd_data[g*DATA_W +: DATA_W];
    assign exe_dep[g] = id_rd_en[g] & (addr == exe_wr_addr);

    always_comb begin
      sel = rf_data;
      if (id_rd_en[g]) begin
        if (exe_wr_en && !exe_is_load && (addr == exe_wr_addr)) begin
          sel = exe_data;
        end else if (mem_wr_en && (addr == mem_wr_addr)) begin
          sel = mem_is_load ? mem_load_data : mem_alu_data;
        end
      end
    end

    assign fwd_data[g*DATA_W +: DATA_W] = sel;
  end

  assign load_use = id_valid & exe_is_load & exe_wr_en & (|exe_dep);

  // Stall controls respond in the detection cycle and are held low during reset.
  always_comb begin
    stall = 1'b0;
    flush = 1'b0;
    if (rst) begin
      case (state)
        RUN: begin
          if (load_use) begin
            stall = 1'b1;
            flush = 1'b1;
          end else if (id_valid && id_is_branch) begin
            stall = 1'b1;
          end
        end
        LD_WAIT: begin
          stall = ~mem_load_done;
          flush = ~mem_load_done;
        end
        BR_HOLD: stall = 1'b1;
        default: begin
          stall = 1'b0;
          flush = 1'b0;
        end
      endcase
    end
  end

  assign stall_pc     = stall;
  assign stall_if_id  = stall;
  assign flush_id_exe = flush;

  // Sequencer and saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      br_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      if (stat_clr) begin
        stall_cnt <= '0;
      end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end

      case (state)
        RUN: begin
          if (load_use) begin
            state <= LD_WAIT;
          end else if (id_valid && id_is_branch && (BR_BUBBLES > 1)) begin
            state  <= BR_HOLD;
            br_cnt <= BR_W'(BR_BUBBLES - 1);
          end
        end
        LD_WAIT: begin
          if (mem_load_done) begin
            state <= RUN;
          end
        end
        BR_HOLD: begin
          br_cnt <= br_cnt - BR_W'(1);
          if (br_cnt == BR_W'(1)) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
